// File: rtl/instr_decode_reg.sv
// instr_decode_reg: instruction register, one-hot opcode decoder and ALU
// flags register for the i281 multicycle CPU.
// Optional feature macro: INSTR_COUNT_EN. When it is defined, instr_count
// is a 16-bit wrapping count of IR loads. When it is undefined, instr_count
// is tied to zero.
module instr_decode_reg (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] instr_in,
    input  logic        ir_load,
    input  logic [3:0]  alu_flags,
    input  logic        flags_load,
    output logic [26:0] opcode_out,
    output logic [7:0]  imm_out,
    output logic [3:0]  flags_reg,
    output logic        dec_valid,
    output logic [15:0] instr_count
);

    logic [15:0] r_ir;
    logic [3:0]  r_flags;
    logic        r_valid;
    logic [22:0] w_onehot;

    // Instruction register: captures the code-memory word when the FSM asks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     r_ir <= 16'h0000;
        else if (ir_load) r_ir <= instr_in;
    end

    // Flags register: sampled by the FSM for branch decisions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        r_flags <= 4'h0;
        else if (flags_load) r_flags <= alu_flags;
    end

    // Sticky flag: IR holds a real word once any load has happened since reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     r_valid <= 1'b0;
        else if (ir_load) r_valid <= 1'b1;
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] r_count;

    // Load counter: wraps naturally at 16 bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     r_count <= 16'h0000;
        else if (ir_load) r_count <= r_count + 16'h0001;
    end

    assign instr_count = r_count;
`else
    assign instr_count = 16'h0000;
`endif

    // One-hot decode of the latched opcode. The sub-op bits pick within the
    // input, shift and branch groups. Every opcode value maps to a single bit.
    always_comb begin
        w_onehot = '0;
        case (r_ir[15:12])
            4'h0: w_onehot[0] = 1'b1;
            4'h1: begin
                case (r_ir[9:8])
                    2'b00: w_onehot[1] = 1'b1;
                    2'b01: w_onehot[2] = 1'b1;
                    2'b10: w_onehot[3] = 1'b1;
                    2'b11: w_onehot[4] = 1'b1;
                endcase
            end
            4'h2: w_onehot[5]  = 1'b1;
            4'h3: w_onehot[6]  = 1'b1;
            4'h4: w_onehot[7]  = 1'b1;
            4'h5: w_onehot[8]  = 1'b1;
            4'h6: w_onehot[9]  = 1'b1;
            4'h7: w_onehot[10] = 1'b1;
            4'h8: w_onehot[11] = 1'b1;
            4'h9: w_onehot[12] = 1'b1;
            4'hA: w_onehot[13] = 1'b1;
            4'hB: w_onehot[14] = 1'b1;
            4'hC: begin
                if (r_ir[8]) w_onehot[16] = 1'b1;
                else         w_onehot[15] = 1'b1;
            end
            4'hD: w_onehot[17] = 1'b1;
            4'hE: w_onehot[18] = 1'b1;
            4'hF: begin
                case (r_ir[9:8])
                    2'b00: w_onehot[19] = 1'b1;
                    2'b01: w_onehot[20] = 1'b1;
                    2'b10: w_onehot[21] = 1'b1;
                    2'b11: w_onehot[22] = 1'b1;
                endcase
            end
        endcase
    end

    // RX and RY are passed through for every opcode. The FSM ignores them where they do not apply.
    assign opcode_out  = {r_ir[11:10], r_ir[9:8], w_onehot};
    assign imm_out     = r_ir[7:0];
    assign flags_reg   = r_flags;
    assign dec_valid   = r_valid;

endmodule
